// File: rtl/ddr_cmd_sequencer.sv
// DDR command sequencer: turns single read/write requests into PR/ACT/RD/WR pin commands,
// tracks the open row of every bank, and inserts periodic PRA+REF refresh sequences.
module ddr_cmd_sequencer #(
    parameter int ADDRWIDTH     = 17,
    parameter int BANKGROUPS    = 1,
    parameter int BANKSPERGROUP = 8,
    parameter int ROWS          = 512,
    parameter int COLUMNS       = 512,
    parameter int TRP           = 4,
    parameter int TRCD          = 4,
    parameter int TCCD          = 4,
    parameter int TRFC          = 16,
    parameter int TREFI         = 1024,
    localparam int BGWIDTH      = $clog2(BANKGROUPS),
    localparam int BAWIDTH      = $clog2(BANKSPERGROUP),
    localparam int RW           = $clog2(ROWS),
    localparam int CW           = $clog2(COLUMNS)
) (
    input  logic                 ck_t,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BGWIDTH:0]     req_bg,
    input  logic [BAWIDTH:0]     req_ba,
    input  logic [RW-1:0]        req_row,
    input  logic [CW-1:0]        req_col,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] adr,
    output logic [BAWIDTH:0]     ba,
    output logic [BGWIDTH:0]     bg,
    output logic                 ref_busy
);

    localparam int NBANKS = BANKGROUPS * BANKSPERGROUP;
    localparam int BIW    = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int REFW   = (TREFI > 1) ? $clog2(TREFI) : 1;
    localparam int LOW    = ADDRWIDTH - 4;
    localparam int WAITW  = 16;
    localparam logic [3:0] OP_ACT = 4'd1, OP_PR = 4'd3, OP_RD = 4'd4, OP_REF = 4'd5, OP_WR = 4'd6;
    localparam logic [LOW-1:0] A10_ALL = LOW'(1) << 10;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_RP, S_WAIT_RCD, S_WAIT_CCD, S_REF_RP, S_REF_RFC
    } state_t;

    state_t             state_q, state_d;
    logic [WAITW-1:0]   wait_q, wait_d;
    logic [REFW-1:0]    refcnt_q, refcnt_d;
    logic               ref_pending_q, ref_pending_d;
    logic [NBANKS-1:0]  open_q, open_d;
    logic [RW-1:0]      row_tbl_q [NBANKS];
    logic [RW-1:0]      row_tbl_d [NBANKS];
    logic               lat_we_q, lat_we_d;
    logic [BGWIDTH:0]   lat_bg_q, lat_bg_d;
    logic [BAWIDTH:0]   lat_ba_q, lat_ba_d;
    logic [RW-1:0]      lat_row_q, lat_row_d;
    logic [CW-1:0]      lat_col_q, lat_col_d;
    logic               cke_q, cke_d, cs_n_q, cs_n_d, act_n_q, act_n_d;
    logic [ADDRWIDTH-1:0] adr_q, adr_d;
    logic [BAWIDTH:0]   cmd_ba_q, cmd_ba_d;
    logic [BGWIDTH:0]   cmd_bg_q, cmd_bg_d;
    logic               req_ready_q, req_ready_d, ref_busy_q, ref_busy_d;
    logic [BIW-1:0]     bank_idx;
    logic               bank_hit, ref_wrap, ref_clear, wait_zero;

    function automatic logic [ADDRWIDTH-1:0] mk_adr(input logic [3:0] op, input logic [LOW-1:0] low);
        return {op, low};
    endfunction

    assign bank_idx  = BIW'(lat_bg_q) * BIW'(BANKSPERGROUP) + BIW'(lat_ba_q);
    assign bank_hit  = open_q[bank_idx] && (row_tbl_q[bank_idx] == lat_row_q);
    assign ref_wrap  = (refcnt_q == REFW'(TREFI - 1));
    assign wait_zero = (wait_q == '0);

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        open_d     = open_q;
        row_tbl_d  = row_tbl_q;
        lat_we_d   = lat_we_q;
        lat_bg_d   = lat_bg_q;
        lat_ba_d   = lat_ba_q;
        lat_row_d  = lat_row_q;
        lat_col_d  = lat_col_q;
        cke_d      = 1'b1;
        cs_n_d     = 1'b1;
        act_n_d    = 1'b1;
        adr_d      = '0;
        cmd_ba_d   = cmd_ba_q;
        cmd_bg_d   = cmd_bg_q;
        ref_busy_d = ref_busy_q;
        ref_clear  = 1'b0;
        refcnt_d   = ref_wrap ? '0 : refcnt_q + REFW'(1);

        case (state_q)
            S_IDLE: begin
                if (ref_pending_q) begin
                    // Only precharge when something is open; otherwise REF follows next cycle.
                    ref_busy_d = 1'b1;
                    state_d    = S_REF_RP;
                    wait_d     = '0;
                    if (|open_q) begin
                        cs_n_d   = 1'b0;
                        adr_d    = mk_adr(OP_PR, A10_ALL);
                        cmd_ba_d = '0;
                        cmd_bg_d = '0;
                        open_d   = '0;
                        wait_d   = WAITW'(TRP - 1);
                    end
                end else if (req_valid && req_ready_q) begin
                    lat_we_d  = req_we;
                    lat_bg_d  = req_bg;
                    lat_ba_d  = req_ba;
                    lat_row_d = req_row;
                    lat_col_d = req_col;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cs_n_d   = 1'b0;
                cmd_ba_d = lat_ba_q;
                cmd_bg_d = lat_bg_q;
                if (bank_hit) begin
                    adr_d   = mk_adr(lat_we_q ? OP_WR : OP_RD, LOW'(lat_col_q));
                    state_d = S_WAIT_CCD;
                    wait_d  = WAITW'(TCCD - 1);
                end else if (open_q[bank_idx]) begin
                    adr_d            = mk_adr(OP_PR, '0);
                    open_d[bank_idx] = 1'b0;
                    state_d          = S_WAIT_RP;
                    wait_d           = WAITW'(TRP - 1);
                end else begin
                    act_n_d             = 1'b0;
                    adr_d               = mk_adr(OP_ACT, LOW'(lat_row_q));
                    open_d[bank_idx]    = 1'b1;
                    row_tbl_d[bank_idx] = lat_row_q;
                    state_d             = S_WAIT_RCD;
                    wait_d              = WAITW'(TRCD - 1);
                end
            end
            S_WAIT_RP: begin
                if (wait_zero) begin
                    cs_n_d              = 1'b0;
                    act_n_d             = 1'b0;
                    adr_d               = mk_adr(OP_ACT, LOW'(lat_row_q));
                    open_d[bank_idx]    = 1'b1;
                    row_tbl_d[bank_idx] = lat_row_q;
                    state_d             = S_WAIT_RCD;
                    wait_d              = WAITW'(TRCD - 1);
                end else begin
                    wait_d = wait_q - WAITW'(1);
                end
            end
            S_WAIT_RCD: begin
                if (wait_zero) begin
                    cs_n_d  = 1'b0;
                    adr_d   = mk_adr(lat_we_q ? OP_WR : OP_RD, LOW'(lat_col_q));
                    state_d = S_WAIT_CCD;
                    wait_d  = WAITW'(TCCD - 1);
                end else begin
                    wait_d = wait_q - WAITW'(1);
                end
            end
            S_WAIT_CCD: begin
                if (wait_zero) state_d = S_IDLE;
                else           wait_d  = wait_q - WAITW'(1);
            end
            S_REF_RP: begin
                if (wait_zero) begin
                    cs_n_d   = 1'b0;
                    adr_d    = mk_adr(OP_REF, '0);
                    cmd_ba_d = '0;
                    cmd_bg_d = '0;
                    state_d  = S_REF_RFC;
                    wait_d   = WAITW'(TRFC - 1);
                end else begin
                    wait_d = wait_q - WAITW'(1);
                end
            end
            S_REF_RFC: begin
                if (wait_zero) begin
                    state_d    = S_IDLE;
                    ref_busy_d = 1'b0;
                    ref_clear  = 1'b1;
                end else begin
                    wait_d = wait_q - WAITW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A wrap during an outstanding refresh is absorbed; a wrap on the clearing edge re-arms.
        ref_pending_d = ref_wrap | (ref_pending_q & ~ref_clear);
        req_ready_d   = (state_d == S_IDLE) && cke_q && !ref_pending_d;
    end

    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            refcnt_q      <= '0;
            ref_pending_q <= 1'b0;
            open_q        <= '0;
            lat_we_q      <= 1'b0;
            lat_bg_q      <= '0;
            lat_ba_q      <= '0;
            lat_row_q     <= '0;
            lat_col_q     <= '0;
            cke_q         <= 1'b0;
            cs_n_q        <= 1'b1;
            act_n_q       <= 1'b1;
            adr_q         <= '0;
            cmd_ba_q      <= '0;
            cmd_bg_q      <= '0;
            req_ready_q   <= 1'b0;
            ref_busy_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            refcnt_q      <= refcnt_d;
            ref_pending_q <= ref_pending_d;
            open_q        <= open_d;
            lat_we_q      <= lat_we_d;
            lat_bg_q      <= lat_bg_d;
            lat_ba_q      <= lat_ba_d;
            lat_row_q     <= lat_row_d;
            lat_col_q     <= lat_col_d;
            cke_q         <= cke_d;
            cs_n_q        <= cs_n_d;
            act_n_q       <= act_n_d;
            adr_q         <= adr_d;
            cmd_ba_q      <= cmd_ba_d;
            cmd_bg_q      <= cmd_bg_d;
            req_ready_q   <= req_ready_d;
            ref_busy_q    <= ref_busy_d;
        end
    end

    // Row entries are only meaningful while the matching open flag is set, so they need no reset.
    always_ff @(posedge ck_t) begin
        row_tbl_q <= row_tbl_d;
    end

    assign req_ready = req_ready_q;
    assign cke       = cke_q;
    assign cs_n      = cs_n_q;
    assign act_n     = act_n_q;
    assign adr       = adr_q;
    assign ba        = cmd_ba_q;
    assign bg        = cmd_bg_q;
    assign ref_busy  = ref_busy_q;

endmodule
